// File: rtl/tx_bit_timer_ctrl.sv
//============================================================================
// Module   : tx_bit_timer_ctrl
// Purpose  : Bit-timing controller and byte scheduler for the USB transmit
//            path. Paces one bit every BIT_PERIOD clocks, pulls bytes from
//            the upstream source at byte boundaries, strobes the downstream
//            shifter, inserts stuff bits on request and times end-of-packet.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - begin a packet (honoured in IDLE only)
//            byte_valid/last - upstream byte handshake and last-byte flag
//            stuff_req       - insert a stuff bit at this bit boundary
//            byte_ready      - byte accepted / shifter parallel-load strobe
//            shift_strobe    - advance shifter by one data bit
//            stuff_strobe    - emit a stuff bit, hold data
//            bit_idx         - data bit currently on the line
//            busy, eop       - packet in progress / EOP interval
//            done, underrun  - single-cycle completion / underrun pulses
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tx_bit_timer_ctrl #(
  parameter int BIT_PERIOD = 8,
  parameter int EOP_BITS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       byte_valid,
  input  logic       byte_last,
  input  logic       stuff_req,
  output logic       byte_ready,
  output logic       shift_strobe,
  output logic       stuff_strobe,
  output logic [2:0] bit_idx,
  output logic       busy,
  output logic       eop,
  output logic       done,
  output logic       underrun
);

  localparam int c_cnt_w = $clog2(BIT_PERIOD + 1);
  // Wide enough to hold EOP_BITS-1 even when EOP_BITS is 1.
  localparam int c_eop_w = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;

  localparam logic [c_cnt_w-1:0] c_period   = c_cnt_w'(BIT_PERIOD);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_eop_w-1:0] c_eop_last = c_eop_w'(EOP_BITS - 1);
  localparam logic [c_eop_w-1:0] c_eop_one  = c_eop_w'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_SEND  = 3'd2,
    S_EOP   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_clk_cnt;
  logic [2:0]           r_bit_cnt;
  logic [c_eop_w-1:0]   r_eop_cnt;
  logic                 r_last_q;

  logic w_boundary;
  logic w_send_bnd;
  logic w_byte_end;

  // Strobes are combinational so the shifter reacts in the boundary cycle
  // itself; this is what lets the next byte load with no gap on the line.
  always_comb begin
    w_boundary   = (r_clk_cnt == c_period);
    w_send_bnd   = (r_state == S_SEND) && w_boundary;
    stuff_strobe = w_send_bnd && stuff_req;
    shift_strobe = w_send_bnd && !stuff_req;
    // A stuff bit on the bit-7 boundary postpones the byte boundary.
    w_byte_end   = shift_strobe && (r_bit_cnt == 3'd7);
    byte_ready   = ((r_state == S_FIRST) && byte_valid) ||
                   (w_byte_end && !r_last_q && byte_valid);
  end

  assign bit_idx  = r_bit_cnt;
  assign busy     = (r_state != S_IDLE);
  assign eop      = (r_state == S_EOP);
  assign done     = (r_state == S_DONE);
  assign underrun = (r_state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_eop_cnt <= '0;
      r_last_q  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FIRST;
        end

        S_FIRST: begin
          if (byte_valid) begin
            r_last_q  <= byte_last;
            r_clk_cnt <= c_cnt_one;
            r_bit_cnt <= 3'd0;
            r_state   <= S_SEND;
          end
        end

        S_SEND: begin
          r_clk_cnt <= w_boundary ? c_cnt_one : (r_clk_cnt + c_cnt_one);
          if (shift_strobe) begin
            if (r_bit_cnt != 3'd7) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (r_last_q) begin
              r_eop_cnt <= '0;
              r_state   <= S_EOP;
            end else if (byte_valid) begin
              r_last_q  <= byte_last;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state   <= S_ERR;
            end
          end
        end

        S_EOP: begin
          if (w_boundary) begin
            r_clk_cnt <= c_cnt_one;
            if (r_eop_cnt == c_eop_last) r_state <= S_DONE;
            else                         r_eop_cnt <= r_eop_cnt + c_eop_one;
          end else begin
            r_clk_cnt <= r_clk_cnt + c_cnt_one;
          end
        end

        // Leave counters cleared so an idle block looks like a reset one.
        S_DONE, S_ERR: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_eop_cnt <= '0;
          r_last_q  <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_bit_timer_ctrl.sv
//============================================================================
// Module   : tb_tx_bit_timer_ctrl
// Purpose  : Self-checking bench for tx_bit_timer_ctrl. Expected strobe /
//            pulse events are queued when a packet is launched and compared
//            in order as the DUT produces them.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tx_bit_timer_ctrl;

  localparam int BP = 4;
  localparam int EB = 2;

  localparam int K_RDY  = 1;
  localparam int K_SHF  = 2;
  localparam int K_STF  = 3;
  localparam int K_DONE = 4;
  localparam int K_UNR  = 5;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       start      = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_last  = 1'b0;
  logic       stuff_req  = 1'b0;
  logic       byte_ready;
  logic       shift_strobe;
  logic       stuff_strobe;
  logic [2:0] bit_idx;
  logic       busy;
  logic       eop;
  logic       done;
  logic       underrun;

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int t0      = 0;
  bit mon_en  = 1'b0;
  int exp_q[$];

  int eop_n, eop_first, eop_last, done_off, shf_n;

  tx_bit_timer_ctrl #(
    .BIT_PERIOD (BP),
    .EOP_BITS   (EB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_last    (byte_last),
    .stuff_req    (stuff_req),
    .byte_ready   (byte_ready),
    .shift_strobe (shift_strobe),
    .stuff_strobe (stuff_strobe),
    .bit_idx      (bit_idx),
    .busy         (busy),
    .eop          (eop),
    .done         (done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event code: offset from T in the high bits, kind and bit index below.
  function automatic int ev(input int off, input int kind, input int idx);
    return off * 64 + kind * 8 + idx;
  endfunction

  task automatic pop_cmp(input int kind, input int idx);
    int got;
    got = ev(cyc - t0, kind, idx);
    if (exp_q.size() == 0) check_val("evt_unexpected", got, -1);
    else                   check_val("evt", got, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (byte_ready)   pop_cmp(K_RDY, 0);
      if (shift_strobe) begin pop_cmp(K_SHF, int'(bit_idx)); shf_n++; end
      if (stuff_strobe) pop_cmp(K_STF, int'(bit_idx));
      if (done)         begin pop_cmp(K_DONE, 0); done_off = cyc - t0; end
      if (underrun)     pop_cmp(K_UNR, 0);
      if (eop) begin
        if (eop_n == 0) eop_first = cyc - t0;
        eop_last = cyc - t0;
        eop_n++;
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample_at(input int c);
    wait_cyc(c);
    @(negedge clk);
  endtask

  // Event-level packet model: one bit every BP cycles from T, stuff slot at
  // offset stuff_at, next byte accepted alongside the 8th shift, then either
  // EB*BP cycles of EOP and done, or an underrun pulse right after.
  task automatic expect_pkt(input int nbytes, input int stuff_at, input bit ends_ok);
    int t;
    int b;
    int idx;
    t = 0; b = 0; idx = 0;
    exp_q.push_back(ev(0, K_RDY, 0));
    while (1) begin
      t += BP;
      if (t == stuff_at) begin
        exp_q.push_back(ev(t, K_STF, idx));
        continue;
      end
      if (idx == 7 && b + 1 < nbytes) exp_q.push_back(ev(t, K_RDY, 0));
      exp_q.push_back(ev(t, K_SHF, idx));
      if (idx < 7) idx++;
      else begin
        b++;
        idx = 0;
        if (b == nbytes) break;
      end
    end
    if (ends_ok) exp_q.push_back(ev(t + EB * BP + 1, K_DONE, 0));
    else         exp_q.push_back(ev(t + 1, K_UNR, 0));
  endtask

  // Pulse start for one cycle; the byte_ready cycle T follows immediately.
  task automatic begin_pkt();
    eop_n = 0; eop_first = -1; eop_last = -1; done_off = -1; shf_n = 0;
    start = 1'b1;
    t0 = cyc + 1;
    wait_cyc(t0);
    start = 1'b0;
  endtask

  task automatic end_pkt(input string tag, input int done_exp, input int shf_exp,
                         input int eop_first_exp);
    check_val({tag, "_done_t"},    done_off,  done_exp);
    check_val({tag, "_shifts"},    shf_n,     shf_exp);
    check_val({tag, "_eop_first"}, eop_first, eop_first_exp);
    check_val({tag, "_eop_len"},   eop_n,     (eop_first_exp < 0) ? 0 : EB * BP);
    check_val({tag, "_q_left"},    exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start and byte_valid high: everything quiet.
    rst = 1'b1; start = 1'b1; byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_outs", {22'd0, byte_ready, shift_strobe, stuff_strobe,
                bit_idx, busy, eop, done, underrun}, 0);
    end
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("idle_hold", {31'd0, busy}, 0);
    end
    mon_en = 1'b1;
    wait_cyc(cyc + 1);

    // Single byte.
    byte_valid = 1'b1; byte_last = 1'b1;
    expect_pkt(1, -1, 1'b1);
    begin_pkt();
    @(negedge clk);
    check_val("single_busy_T", {31'd0, busy}, 1);
    sample_at(t0 + 41);
    check_val("single_busy_41", {31'd0, busy}, 1);
    sample_at(t0 + 42);
    check_val("single_busy_42", {31'd0, busy}, 0);
    end_pkt("single", 41, 8, 33);
    check_val("single_eop_last", eop_last, 40);

    // Back-to-back bytes, last flag on the second only.
    wait_cyc(cyc + 3);
    byte_valid = 1'b1; byte_last = 1'b0;
    expect_pkt(2, -1, 1'b1);
    begin_pkt();
    wait_cyc(t0 + 1);
    byte_last = 1'b1;
    sample_at(t0 + 75);
    check_val("b2b_busy_end", {31'd0, busy}, 0);
    end_pkt("b2b", 73, 16, 65);

    // Stuff bit on the T+12 boundary.
    wait_cyc(cyc + 3);
    byte_valid = 1'b1; byte_last = 1'b1;
    expect_pkt(1, 12, 1'b1);
    begin_pkt();
    wait_cyc(t0 + 12);
    stuff_req = 1'b1;
    wait_cyc(t0 + 13);
    stuff_req = 1'b0;
    sample_at(t0 + 48);
    end_pkt("stuff", 45, 8, 37);

    // Underrun: no second byte at the boundary.
    wait_cyc(cyc + 3);
    byte_valid = 1'b1; byte_last = 1'b0;
    expect_pkt(1, -1, 1'b0);
    begin_pkt();
    wait_cyc(t0 + 32);
    byte_valid = 1'b0;
    sample_at(t0 + 33);
    check_val("unr_pulse", {31'd0, underrun}, 1);
    sample_at(t0 + 34);
    check_val("unr_busy", {31'd0, busy}, 0);
    sample_at(t0 + 40);
    end_pkt("unr", -1, 8, -1);

    // Start while busy is ignored; reset mid-byte kills the packet silently.
    wait_cyc(cyc + 3);
    byte_valid = 1'b1; byte_last = 1'b1;
    exp_q.push_back(ev(0, K_RDY, 0));
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(4 * (i + 1), K_SHF, i));
    begin_pkt();
    wait_cyc(t0 + 6);
    start = 1'b1;
    wait_cyc(t0 + 7);
    start = 1'b0;
    wait_cyc(t0 + 14);
    rst = 1'b1;
    wait_cyc(t0 + 15);
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_outs", {22'd0, byte_ready, shift_strobe, stuff_strobe,
              bit_idx, busy, eop, done, underrun}, 0);
    sample_at(t0 + 30);
    check_val("midrst_busy", {31'd0, busy}, 0);
    end_pkt("midrst", -1, 3, -1);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tx_bit_timer_ctrl.md
# tx_bit_timer_ctrl

Bit-timing controller and byte scheduler for the USB transmit path. It sequences a bit-period counter and a bit-in-byte counter, pops bytes from the upstream byte source, and strobes the downstream shift/NRZI logic. It inserts stuff bits on request and times the end-of-packet interval, signalling completion or underrun to the packet controller.

## Interface
- `BIT_PERIOD`, default 8: clock cycles per bit; legal range ≥2.
- `EOP_BITS`, default 2: bit periods spent in EOP; legal range ≥1.
- `clk` in 1: system clock; all logic is rising-edge.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: begin packet; sampled only in IDLE.
- `byte_valid` in 1: upstream holds a byte.
- `byte_last` in 1: the offered byte is the final one; qualified by `byte_valid`.
- `stuff_req` in 1: insert a stuff bit at the current bit boundary.
- `byte_ready` out 1: byte accepted this cycle; also serves as the shifter parallel-load strobe.
- `shift_strobe` out 1: one-cycle pulse; advance the shifter by one data bit.
- `stuff_strobe` out 1: one-cycle pulse; emit a stuff bit and do not advance data.
- `bit_idx` out 3: index of the data bit currently on the line (0–7).
- `busy` out 1: high in every state except IDLE.
- `eop` out 1: high for the whole EOP interval.
- `done` out 1: one-cycle pulse at the end of EOP.
- `underrun` out 1: one-cycle pulse when the next byte is missing at a byte boundary.

## Operation
- Internal counters:
  - `clk_cnt` is $clog2(BIT_PERIOD+1) bits wide and runs 1..BIT_PERIOD. It wraps to 1 on the boundary cycle, i.e. the cycle where `clk_cnt`==BIT_PERIOD.
  - `bit_cnt` is 3 bits (0..7) and drives `bit_idx`.
  - `eop_cnt` counts bit periods during EOP.
- States:
  - **IDLE**: `start` moves to FIRST. Otherwise remain.
  - **FIRST**: waits indefinitely for `byte_valid`. When it is high:
    - assert `byte_ready`;
    - latch `byte_last` into `last_q`;
    - set `clk_cnt`=1 and `bit_cnt`=0;
    - move to SEND.
  - **SEND**: `clk_cnt` increments every cycle. Behaviour on a boundary cycle:
    - If `stuff_req`=1: assert `stuff_strobe`. `bit_cnt` holds.
    - Otherwise: assert `shift_strobe`. If `bit_cnt`<7, increment `bit_cnt`.
    - If `bit_cnt`==7 with no stuff (the byte boundary), take exactly one of:
      - `last_q`=1: go to EOP with `clk_cnt`=1 and `eop_cnt`=0.
      - `last_q`=0 and `byte_valid`=1: assert `byte_ready` in the same cycle, latch `byte_last`, set `bit_cnt`=0, stay in SEND. The line has no gap.
      - `last_q`=0 and `byte_valid`=0: go to ERR.
  - **EOP**: `eop`=1. `clk_cnt` cycles as in SEND. Each boundary increments `eop_cnt`. The boundary where `eop_cnt`==EOP_BITS-1 moves to DONE.
  - **DONE**: `done`=1 for one cycle, then IDLE.
  - **ERR**: `underrun`=1 for one cycle, then IDLE.
- `byte_ready`, `shift_strobe` and `stuff_strobe` are decoded combinationally from state, counters, `byte_valid` and `stuff_req`. All other outputs decode from registered state only.
- `stuff_req` is ignored outside SEND boundary cycles.
- `start` is ignored outside IDLE.
- `byte_valid` is not sampled outside FIRST and SEND byte-boundary cycles.

## Timing
- Reset: on the edge with `rst`=1, the block enters IDLE.
  - All counters are 0.
  - All outputs are 0.
  - `rst` has priority over every other input in every state.
  - Reset mid-packet produces no `done` and no `underrun`.
- Start latency: `start` sampled at edge E places the block in FIRST after E. `busy` is high from that cycle.
- Byte timing, taking the `byte_ready` cycle as T:
  - the first bit boundary falls at T+BIT_PERIOD;
  - the eighth boundary falls at T+8·BIT_PERIOD;
  - each stuff bit adds BIT_PERIOD cycles.
- The next `byte_ready` coincides with the eighth `shift_strobe` of the current byte.
- A stuff request on the bit_idx=7 boundary delays the byte boundary by one bit period.
- EOP: `eop` is high for EOP_BITS·BIT_PERIOD cycles, starting the cycle after the final `shift_strobe`.
  - `done` follows in the next cycle.
  - `busy` drops the cycle after `done`.
- At most one of `byte_ready`, `done` and `underrun` is high per cycle, except `byte_ready` together with `shift_strobe` at a byte boundary.
- `shift_strobe` and `stuff_strobe` are never high together.

## Test plan
Parameters for all scenarios: BIT_PERIOD=4, EOP_BITS=2.
- **Reset:**
  - Stimulus: hold `rst` for 3 cycles with `start`=1 and `byte_valid`=1.
  - Required response: every output 0 and `busy`=0 throughout. Release `rst`; IDLE holds until `start` is sampled.
- **Single byte:**
  - Stimulus: `start`, `byte_valid`=1, `byte_last`=1.
  - Required response:
    - `byte_ready` at cycle T;
    - `shift_strobe` at T+4, T+8, …, T+32, with `bit_idx` 0..7;
    - `eop` high T+33..T+40;
    - `done` at T+41;
    - `busy` low at T+42.
- **Back-to-back:**
  - Stimulus: two bytes, `byte_valid` always high, `byte_last` on the second byte only.
  - Required response: second `byte_ready` at T+32, in the same cycle as the 8th `shift_strobe`. Total `shift_strobe` count 16. `done` at T+73.
- **Stuff:**
  - Stimulus: `stuff_req` pulsed on the T+12 boundary of a single-byte packet.
  - Required response:
    - `stuff_strobe` at T+12 with `bit_idx` held at 2;
    - 8 `shift_strobe` pulses, the last at T+36;
    - `done` at T+45.
- **Underrun:**
  - Stimulus: first byte with `byte_last`=0, then `byte_valid`=0 at T+32.
  - Required response: no second `byte_ready`. `underrun` pulse at T+33. `busy`=0 at T+34. No `done`.
- **Reset mid-byte, and start while busy:**
  - Stimulus: pulse `start` during SEND; later assert `rst` at T+14.
  - Required response: the `start` pulse has no effect. `rst` at T+14 gives all outputs 0 from T+15, with no further strobes.
